// File: rtl/alu_writeback.sv
// ALU writeback stage: captures one ALU completion through a valid/ready
// handshake and commits it into a 16 x 16-bit register file over one or
// two write cycles. Two combinational read ports feed operand fetch.
module alu_writeback #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int REM_REG = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        funct_code,
    input  logic [ADDR_W-1:0] rd_a,
    input  logic [ADDR_W-1:0] rd_b,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] remainder,
    input  logic [DATA_W-1:0] op2,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              err,
    output logic [15:0]       retired
);

    // state | meaning
    // IDLE  | nothing held, ready for a completion
    // WR1   | primary write of the held op (err pulses here for bad ops)
    // WR2   | secondary write (remainder or swap operand)
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR1  = 2'd1;
    localparam logic [1:0] S_WR2  = 2'd2;

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b0001;
    localparam logic [3:0] F_MUL  = 4'b0100;
    localparam logic [3:0] F_DIV  = 4'b0101;
    localparam logic [3:0] F_MOV  = 4'b0111;
    localparam logic [3:0] F_SWAP = 4'b1000;

    localparam int                NREGS    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] REM_ADDR = ADDR_W'(REM_REG);

    logic [1:0]        state_q, state_d;
    logic [3:0]        funct_q;
    logic [ADDR_W-1:0] rda_q, rdb_q;
    logic [DATA_W-1:0] result_q, rem_q, op2_q;
    logic [15:0]       retired_q, retired_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              is_single, is_mul, is_div, is_swap, div_zero;
    logic              needs_second, bad_op, accept, retire;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Decode the held function code into write behaviour.
    always_comb begin
        is_single    = (funct_q == F_ADD) || (funct_q == F_SUB) || (funct_q == F_MOV);
        is_mul       = (funct_q == F_MUL);
        is_div       = (funct_q == F_DIV);
        is_swap      = (funct_q == F_SWAP);
        div_zero     = is_div && (op2_q == '0);
        needs_second = is_mul || (is_div && !div_zero) || is_swap;
        bad_op       = !(is_single || is_mul || is_div || is_swap) || div_zero;
    end

    // Handshake: a two-write op blocks the cycle of its first write.
    always_comb begin
        in_ready = !rst && ((state_q == S_IDLE) ||
                            ((state_q == S_WR1) && !needs_second) ||
                            (state_q == S_WR2));
        accept   = in_valid && in_ready;
        retire   = ((state_q == S_WR1) && !needs_second) || (state_q == S_WR2);
        err      = (state_q == S_WR1) && bad_op;
    end

    // Select the register-file write for the current phase.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (state_q == S_WR1) begin
            if (is_swap) begin
                we    = 1'b1;
                waddr = rdb_q;
                wdata = result_q;
            end else if (is_single || is_mul || (is_div && !div_zero)) begin
                we    = 1'b1;
                waddr = rda_q;
                wdata = result_q;
            end
        end else if (state_q == S_WR2) begin
            we = 1'b1;
            if (is_swap) begin
                waddr = rda_q;
                wdata = op2_q;
            end else begin
                waddr = REM_ADDR;
                wdata = rem_q;
            end
        end
    end

    // Next-state and retire-counter logic.
    always_comb begin
        state_d   = S_IDLE;
        retired_d = retired_q + (retire ? 16'd1 : 16'd0);
        case (state_q)
            S_IDLE:  state_d = accept ? S_WR1 : S_IDLE;
            S_WR1:   state_d = needs_second ? S_WR2 : (accept ? S_WR1 : S_IDLE);
            S_WR2:   state_d = accept ? S_WR1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, hold registers and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
            funct_q   <= '0;
            rda_q     <= '0;
            rdb_q     <= '0;
            result_q  <= '0;
            rem_q     <= '0;
            op2_q     <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            if (accept) begin
                funct_q  <= funct_code;
                rda_q    <= rd_a;
                rdb_q    <= rd_b;
                result_q <= result;
                rem_q    <= remainder;
                op2_q    <= op2;
            end
        end
    end

    // Register file; r0 is never written so it always holds zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
    assign retired  = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  funct_code;
    logic [3:0]  rd_a, rd_b;
    logic [15:0] result, remainder, op2;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [15:0] rs1_data, rs2_data;
    logic        err;
    logic [15:0] retired;

    int n_vec  = 0;
    int n_miss = 0;

    alu_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct_code (funct_code),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .result     (result),
        .remainder  (remainder),
        .op2        (op2),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .err        (err),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  f;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] res;
        logic [15:0] rem;
        logic [15:0] o2;
        int          exp_err;
        logic [3:0]  ca1;
        logic [15:0] cv1;
        logic [3:0]  ca2;
        logic [15:0] cv2;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 16; a++) begin
            rs1_addr = 4'(a);
            #1;
            check($sformatf("%s r%0d", name, a), rs1_data, 16'h0000);
        end
    endtask

    task automatic do_op(input vec_t v, input int idx);
        int  errs;
        bit  ok;
        @(negedge clk);
        funct_code = v.f;
        rd_a       = v.ra;
        rd_b       = v.rb;
        result     = v.res;
        remainder  = v.rem;
        op2        = v.o2;
        in_valid   = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 8; w++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL vec%0d accept: got in_ready 0 expected 1 within 8 cycles", idx);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (err) errs++;
            @(negedge clk);
        end
        rs1_addr = v.ca1;
        rs2_addr = v.ca2;
        #1;
        check($sformatf("vec%0d err cycles", idx), 16'(errs), 16'(v.exp_err));
        check($sformatf("vec%0d r%0d", idx, v.ca1), rs1_data, v.cv1);
        check($sformatf("vec%0d r%0d", idx, v.ca2), rs2_data, v.cv2);
        check($sformatf("vec%0d retired", idx), retired, 16'(idx + 1));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          f      ra     rb     res       rem       op2     err ca1    cv1       ca2    cv2
        vecs[0]  = '{4'h0, 4'd3,  4'd0,  16'h1234, 16'h0000, 16'h0000, 0, 4'd3,  16'h1234, 4'd0,  16'h0000};
        vecs[1]  = '{4'h1, 4'd4,  4'd0,  16'hFFFF, 16'h0000, 16'h0000, 0, 4'd4,  16'hFFFF, 4'd3,  16'h1234};
        vecs[2]  = '{4'h7, 4'd6,  4'd0,  16'h8001, 16'h0000, 16'h0000, 0, 4'd6,  16'h8001, 4'd4,  16'hFFFF};
        vecs[3]  = '{4'h4, 4'd7,  4'd0,  16'h00C8, 16'h0001, 16'h0000, 0, 4'd7,  16'h00C8, 4'd15, 16'h0001};
        vecs[4]  = '{4'h5, 4'd5,  4'd0,  16'h0007, 16'h0002, 16'h0003, 0, 4'd5,  16'h0007, 4'd15, 16'h0002};
        vecs[5]  = '{4'h8, 4'd1,  4'd2,  16'hAAAA, 16'h0000, 16'h5555, 0, 4'd2,  16'hAAAA, 4'd1,  16'h5555};
        vecs[6]  = '{4'h8, 4'd1,  4'd1,  16'h1111, 16'h0000, 16'h3333, 0, 4'd1,  16'h3333, 4'd2,  16'hAAAA};
        vecs[7]  = '{4'h5, 4'd9,  4'd0,  16'hBEEF, 16'hDEAD, 16'h0000, 1, 4'd9,  16'h0000, 4'd15, 16'h0002};
        vecs[8]  = '{4'h3, 4'd10, 4'd0,  16'hCAFE, 16'h0000, 16'h0000, 1, 4'd10, 16'h0000, 4'd4,  16'hFFFF};
        vecs[9]  = '{4'h0, 4'd0,  4'd0,  16'h7777, 16'h0000, 16'h0000, 0, 4'd0,  16'h0000, 4'd3,  16'h1234};
        vecs[10] = '{4'h4, 4'd15, 4'd0,  16'h1111, 16'h2222, 16'h0000, 0, 4'd15, 16'h2222, 4'd7,  16'h00C8};
        vecs[11] = '{4'hF, 4'd11, 4'd0,  16'h9999, 16'h0000, 16'h0000, 1, 4'd11, 16'h0000, 4'd5,  16'h0007};
        vecs[12] = '{4'h5, 4'd12, 4'd0,  16'h0042, 16'h0000, 16'h0001, 0, 4'd12, 16'h0042, 4'd15, 16'h0000};

        rst = 1'b1;
        in_valid = 1'b0;
        funct_code = '0;
        rd_a = '0;
        rd_b = '0;
        result = '0;
        remainder = '0;
        op2 = '0;
        rs1_addr = '0;
        rs2_addr = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("ready during reset", {15'd0, in_ready}, 16'h0000);
        check("err after reset", {15'd0, err}, 16'h0000);
        check("retired after reset", retired, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready after release", {15'd0, in_ready}, 16'h0001);
        check_all_zero("reset regs");

        // Write latency and back-to-back single writes
        @(negedge clk);
        funct_code = 4'h0; rd_a = 4'd3; result = 16'h1234; in_valid = 1'b1;
        rs1_addr = 4'd3; rs2_addr = 4'd4;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("add WR1 old r3", rs1_data, 16'h0000);
        check("add WR1 ready", {15'd0, in_ready}, 16'h0001);
        rd_a = 4'd4; result = 16'h4321;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("add r3 after E1", rs1_data, 16'h1234);
        check("add2 r4 before write", rs2_data, 16'h0000);
        check("retired after one", retired, 16'h0001);
        @(negedge clk);
        #1;
        check("add2 r4 after write", rs2_data, 16'h4321);
        check("retired after two", retired, 16'h0002);

        // Divide: blocks during WR1, two-step commit
        @(negedge clk);
        funct_code = 4'h5; rd_a = 4'd5; result = 16'h0007; remainder = 16'h0002; op2 = 16'h0003;
        in_valid = 1'b1;
        rs1_addr = 4'd5; rs2_addr = 4'd15;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("div WR1 ready", {15'd0, in_ready}, 16'h0000);
        check("div WR1 err", {15'd0, err}, 16'h0000);
        check("div WR1 old r5", rs1_data, 16'h0000);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("div r5 after E1", rs1_data, 16'h0007);
        check("div r15 before E2", rs2_data, 16'h0000);
        check("div WR2 ready", {15'd0, in_ready}, 16'h0001);
        @(negedge clk);
        #1;
        check("div r15 after E2", rs2_data, 16'h0002);
        check("div retired", retired, 16'h0003);

        // Table-driven vectors from a clean reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) do_op(vecs[i], i);

        // Reset while a multiply is in WR1; completion offered during reset
        @(negedge clk);
        funct_code = 4'h4; rd_a = 4'd3; result = 16'h5A5A; remainder = 16'hA5A5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        funct_code = 4'h0; rd_a = 4'd6; result = 16'h6666;
        #1;
        check("ready in mid-op reset", {15'd0, in_ready}, 16'h0000);
        @(negedge clk);
        #1;
        check("ready in reset 2nd cycle", {15'd0, in_ready}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("retired after mid-op reset", retired, 16'h0000);
        check_all_zero("mid-op reset");

        // Retire counter wrap with continuous single-write ops
        @(negedge clk);
        funct_code = 4'h0; rd_a = 4'd2; result = 16'h0BAD; in_valid = 1'b1;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        #1;
        check("retired before wrap", retired, 16'hFFFF);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("retired after wrap", retired, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the ALU. Captures each ALU completion (result, remainder, function code, destination indices) through a valid/ready handshake. Commits it into a 16-entry x 16-bit register file over one or two write cycles. Exposes two combinational read ports that feed operand fetch for the next ALU operation.

## Interface
- DATA_W, 16, register and datapath width
- ADDR_W, 4, register index width (2**ADDR_W registers)
- REM_REG, 15, register index that receives the remainder on multiply/divide

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU completion present
- in_ready  out  1  stage can accept a completion this cycle
- funct_code  in  4  ALU function code of the completed op
- rd_a  in  ADDR_W  primary destination
- rd_b  in  ADDR_W  secondary destination (swap only)
- result  in  DATA_W  ALU result
- remainder  in  DATA_W  ALU remainder
- op2  in  DATA_W  second ALU operand (swap data, divide-by-zero check)
- rs1_addr, rs2_addr  in  ADDR_W  read-port addresses
- rs1_data, rs2_data  out  DATA_W  read-port data, combinational
- err  out  1  one-cycle pulse: illegal code or divide by zero
- retired  out  16  count of committed ops, wraps 0xFFFF -> 0x0000

## Operation
- Accept on a rising edge where in_valid && in_ready. All inputs are latched into hold registers.
- FSM states: IDLE, WR1, WR2.
  - IDLE --accept--> WR1.
  - WR1 --needs second write--> WR2.
  - WR1 --no second write, accept--> WR1.
  - WR1 --no second write, no accept--> IDLE.
  - WR2 --accept--> WR1.
  - WR2 --no accept--> IDLE.
- in_ready = !rst && (IDLE || (WR1 && !needs_second) || WR2).
- Writes per code:
  - 0000 add, 0001 sub, 0111 move: WR1 writes result -> rd_a. Single write.
  - 0100 mul: WR1 writes result -> rd_a. WR2 writes remainder -> REM_REG.
  - 0101 div, op2 != 0: as mul.
  - 0101 div, op2 == 0: no writes. err pulses in WR1. Counts as retired.
  - 1000 swap: WR1 writes result -> rd_b. WR2 writes held op2 -> rd_a.
  - Any other code: no writes. err pulses in WR1. Counts as retired.
- Register 0 reads as 0. Writes to it are discarded; a write phase targeting it still consumes its cycle.
- Data is stored bit-exact; no sign or width manipulation.
- retired increments by 1 on the edge that completes the op's last phase: WR1 edge for single-write ops, WR2 edge otherwise.

## Timing
- Reset (rst high at an edge):
  - all registers 0
  - FSM IDLE
  - err 0, retired 0
  - in_ready 0 while rst is high, 1 the cycle after rst is released
- Reset mid-operation drops any pending WR1/WR2 write. A completion presented during reset is not accepted.
- Latency: accept at edge E0; primary write at E1, visible on read ports after E1; secondary write at E2, visible after E2.
- Throughput: one single-write op per cycle; one two-write op per 2 cycles.
- Read ports are asynchronous with no bypass. A read of the address being written returns the old value until the write edge.
- Two-write ops with rd_a == rd_b (swap) or rd_a == REM_REG (mul/div): the WR2 value wins.
- err is high only during the WR1 cycle of the offending op.

## Test plan
- Reset, then read all 16 registers -> all 0x0000; in_ready=1, retired=0.
- Add result 0x1234 to rd_a=3:
  - rs1_addr=3 reads 0x0000 in WR1 and 0x1234 after E1
  - back-to-back second add to r4 is accepted in WR1 (in_ready=1) and commits next edge
  - retired=2
- Div result 0x0007, remainder 0x0002, rd_a=5, op2=3:
  - in_ready=0 during WR1
  - r5=0x0007 after E1, r15=0x0002 after E2
  - retired increments once
- Swap result 0xAAAA, op2 0x5555, rd_a=1, rd_b=2 -> r2=0xAAAA after E1, r1=0x5555 after E2. With rd_a=rd_b=1 -> r1=0x5555.
- Div op2=0 and funct_code=0011 -> no register changes, err pulses one cycle each, retired +2. Write to r0 -> r0 reads 0x0000.
- Assert rst during WR1 of a mul -> no write lands, all registers 0, retired=0. 65536 single-write ops -> retired wraps to 0x0000.
